// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states
// and small op-decode helpers.
package mdu_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned OP_W      = 3;

    localparam logic [OP_W-1:0] OP_MULT  = 3'b000;
    localparam logic [OP_W-1:0] OP_MULTU = 3'b001;
    localparam logic [OP_W-1:0] OP_DIV   = 3'b010;
    localparam logic [OP_W-1:0] OP_DIVU  = 3'b011;
    localparam logic [OP_W-1:0] OP_MTHI  = 3'b100;
    localparam logic [OP_W-1:0] OP_MTLO  = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // 11x encodings are reserved and behave as NOP
    function automatic logic is_valid_op(input logic [OP_W-1:0] op);
        return op[2:1] != 2'b11;
    endfunction

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath on latched operands; returns the
// {hi,lo} pair and flags a zero divisor so the caller can leave HI/LO alone.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
)(
    input  logic [OP_W-1:0]    i_op,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_result_c,
    output logic               o_div_by_zero_c
);

    logic signed [2*WIDTH-1:0] w_sa;
    logic signed [2*WIDTH-1:0] w_sb;
    logic signed [2*WIDTH-1:0] w_sprod;
    logic        [2*WIDTH-1:0] w_uprod;
    logic                      w_b_zero;
    logic                      w_neg_a;
    logic                      w_neg_b;
    logic        [WIDTH-1:0]   w_mag_a;
    logic        [WIDTH-1:0]   w_mag_b;
    logic        [WIDTH-1:0]   w_sq;
    logic        [WIDTH-1:0]   w_sr;
    logic        [WIDTH-1:0]   w_q_s;
    logic        [WIDTH-1:0]   w_r_s;
    logic        [WIDTH-1:0]   w_ub;
    logic        [WIDTH-1:0]   w_uq;
    logic        [WIDTH-1:0]   w_ur;

    assign w_sa    = {{WIDTH{i_a[WIDTH-1]}}, i_a};
    assign w_sb    = {{WIDTH{i_b[WIDTH-1]}}, i_b};
    assign w_sprod = w_sa * w_sb;
    assign w_uprod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

    // Signed divide on magnitudes; MIN/-1 wraps back to MIN with zero remainder
    assign w_b_zero = (i_b == '0);
    assign w_neg_a  = i_a[WIDTH-1];
    assign w_neg_b  = i_b[WIDTH-1];
    assign w_mag_a  = w_neg_a ? (~i_a + WIDTH'(1)) : i_a;
    assign w_mag_b  = w_b_zero ? WIDTH'(1) : (w_neg_b ? (~i_b + WIDTH'(1)) : i_b);
    assign w_sq     = w_mag_a / w_mag_b;
    assign w_sr     = w_mag_a % w_mag_b;
    assign w_q_s    = (w_neg_a ^ w_neg_b) ? (~w_sq + WIDTH'(1)) : w_sq;
    assign w_r_s    = w_neg_a ? (~w_sr + WIDTH'(1)) : w_sr;

    assign w_ub = w_b_zero ? WIDTH'(1) : i_b;
    assign w_uq = i_a / w_ub;
    assign w_ur = i_a % w_ub;

    always_comb begin
        o_result_c      = '0;
        o_div_by_zero_c = is_div_op(i_op) && w_b_zero;
        case (i_op)
            OP_MULT:  o_result_c = w_sprod;
            OP_MULTU: o_result_c = w_uprod;
            OP_DIV:   o_result_c = {w_r_s, w_q_s};
            OP_DIVU:  o_result_c = {w_ur, w_uq};
            default:  o_result_c = '0;
        endcase
    end

endmodule

// File: rtl/mdu_hilo.sv
// EX-stage multiply/divide unit with HI/LO registers and fixed-latency Busy;
// results land in HI/LO only on the final cycle, alongside a one-cycle Done.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH       = WIDTH_DEF,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
)(
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [OP_W-1:0]  Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    state_t             r_state, w_state_nx;
    logic [CNT_W-1:0]   r_cnt,   w_cnt_nx;
    logic [OP_W-1:0]    r_op,    w_op_nx;
    logic [WIDTH-1:0]   r_a,     w_a_nx;
    logic [WIDTH-1:0]   r_b,     w_b_nx;
    logic [WIDTH-1:0]   r_hi,    w_hi_nx;
    logic [WIDTH-1:0]   r_lo,    w_lo_nx;
    logic               r_busy,  w_busy_nx;
    logic               r_done,  w_done_nx;

    logic [2*WIDTH-1:0] w_result;
    logic               w_div_by_zero;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .i_op            (r_op),
        .i_a             (r_a),
        .i_b             (r_b),
        .o_result_c      (w_result),
        .o_div_by_zero_c (w_div_by_zero)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_MULT;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_op    <= w_op_nx;
            r_a     <= w_a_nx;
            r_b     <= w_b_nx;
            r_hi    <= w_hi_nx;
            r_lo    <= w_lo_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

    // Counter loads N-1 on accept and the op retires on the edge after it hits 0
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_op_nx    = r_op;
        w_a_nx     = r_a;
        w_b_nx     = r_b;
        w_hi_nx    = r_hi;
        w_lo_nx    = r_lo;
        w_done_nx  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Start && is_valid_op(Op)) begin
                    if (Op == OP_MTHI) begin
                        w_hi_nx = A;
                    end else if (Op == OP_MTLO) begin
                        w_lo_nx = A;
                    end else begin
                        w_state_nx = ST_RUN;
                        w_op_nx    = Op;
                        w_a_nx     = A;
                        w_b_nx     = B;
                        w_cnt_nx   = is_div_op(Op) ? CNT_W'(DIV_CYCLES - 1)
                                                   : CNT_W'(MULT_CYCLES - 1);
                    end
                end
            end
            ST_RUN: begin
                if (r_cnt == '0) begin
                    w_state_nx = ST_IDLE;
                    w_done_nx  = 1'b1;
                    if (!w_div_by_zero) begin
                        w_hi_nx = w_result[2*WIDTH-1:WIDTH];
                        w_lo_nx = w_result[WIDTH-1:0];
                    end
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
        w_busy_nx = (w_state_nx == ST_RUN);
    end

    assign Busy = r_busy;
    assign Done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: an arithmetic reference model queues the
// expected HI/LO/Done per retirement edge; a negedge monitor checks every cycle.
module tb_mdu_hilo;

    localparam int unsigned W      = 32;
    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b1;
    logic          Start = 1'b0;
    logic [2:0]    Op = 3'b000;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          Busy;
    logic          Done;
    logic [W-1:0]  HI;
    logic [W-1:0]  LO;

    mdu_hilo #(.WIDTH(W), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Start   (Start),
        .Op      (Op),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .HI      (HI),
        .LO      (LO)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int unsigned  done_edge;
        bit           md;
    } exp_t;

    exp_t         q[$];
    int unsigned  edge_cnt   = 0;
    int unsigned  busy_start = 1;
    int unsigned  busy_end   = 0;
    logic [W-1:0] m_hi  = '0;
    logic [W-1:0] m_lo  = '0;
    logic [W-1:0] vis_hi = '0;
    logic [W-1:0] vis_lo = '0;
    int           checks = 0;
    int           errors = 0;

    always @(posedge Clk) edge_cnt <= edge_cnt + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %h expected %h", name, edge_cnt, act, exp);
        end
    endfunction

    // Reference model: decides acceptance and computes HI/LO from MIPS semantics
    function automatic void model_accept(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input int unsigned e);
        exp_t    ent;
        int      sa, sb, qq, rr;
        longint  sp;
        longint unsigned up;
        int unsigned n;
        sa = a;
        sb = b;
        n  = MULT_N;
        case (op)
            3'b100: m_hi = a;
            3'b101: m_lo = a;
            3'b000: begin sp = longint'(sa) * longint'(sb); m_hi = sp[63:32]; m_lo = sp[31:0]; end
            3'b001: begin up = 64'(a) * 64'(b); m_hi = up[63:32]; m_lo = up[31:0]; end
            3'b010: begin
                n = DIV_N;
                if (b == 0) begin
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000; m_hi = '0;
                end else begin
                    qq = sa / sb; rr = sa % sb; m_lo = qq; m_hi = rr;
                end
            end
            default: begin
                n = DIV_N;
                if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            end
        endcase
        ent.hi = m_hi;
        ent.lo = m_lo;
        if (op[2]) begin
            ent.done_edge = e;
            ent.md        = 1'b0;
        end else begin
            ent.done_edge = e + n;
            ent.md        = 1'b1;
            busy_start    = e;
            busy_end      = e + n;
        end
        q.push_back(ent);
    endfunction

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned e;
        @(negedge Clk);
        Start = 1'b1; Op = op; A = a; B = b;
        e = edge_cnt + 1;
        if (op[2:1] != 2'b11 && e > busy_end) model_accept(op, a, b, e);
        @(negedge Clk);
        Start = 1'b0; Op = 3'($urandom); A = $urandom; B = $urandom;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        q.delete();
        busy_end = 0;
        m_hi = '0; m_lo = '0; vis_hi = '0; vis_lo = '0;
        #1;
        chk("rst_hi",   64'(HI),   64'(0));
        chk("rst_lo",   64'(LO),   64'(0));
        chk("rst_busy", 64'(Busy), 64'(0));
        chk("rst_done", 64'(Done), 64'(0));
        repeat (2) @(negedge Clk);
        #2 Reset_n = 1'b1;
    endtask

    // Monitor: retire queued expectations on their edge, check all outputs each cycle
    always @(negedge Clk) begin
        exp_t ent;
        bit   exp_done;
        exp_done = 1'b0;
        if (q.size() != 0 && q[0].done_edge == edge_cnt) begin
            ent = q.pop_front();
            vis_hi   = ent.hi;
            vis_lo   = ent.lo;
            exp_done = ent.md;
        end
        chk("busy", 64'(Busy), 64'(busy_start <= edge_cnt && edge_cnt < busy_end));
        chk("done", 64'(Done), 64'(exp_done));
        chk("hi",   64'(HI),   64'(vis_hi));
        chk("lo",   64'(LO),   64'(vis_lo));
    end

    initial begin
        logic [2:0]   op;
        logic [W-1:0] a, b;
        int           drain;
        #2 do_reset();
        repeat (3) @(negedge Clk);

        issue(3'b000, 32'hFFFF_FFFF, 32'h0000_0002);
        repeat (MULT_N + 2) @(negedge Clk);
        issue(3'b001, 32'hFFFF_FFFF, 32'h0000_0002);
        repeat (MULT_N + 2) @(negedge Clk);
        issue(3'b010, 32'hFFFF_FFF9, 32'h0000_0002);
        repeat (DIV_N + 2) @(negedge Clk);
        issue(3'b011, 32'h0000_0007, 32'h0000_0002);
        repeat (DIV_N + 2) @(negedge Clk);
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (DIV_N + 2) @(negedge Clk);

        issue(3'b100, 32'h0000_1234, 32'h0);
        issue(3'b101, 32'h0000_5678, 32'h0);
        issue(3'b011, 32'h0000_0005, 32'h0);
        repeat (DIV_N + 2) @(negedge Clk);

        issue(3'b000, 32'h0000_0003, 32'h0000_0004);
        issue(3'b101, 32'h0000_AAAA, 32'h0);
        repeat (MULT_N + 2) @(negedge Clk);

        issue(3'b110, 32'h0000_0009, 32'h0000_0003);
        issue(3'b111, 32'h0000_0009, 32'h0000_0003);

        issue(3'b010, $urandom, 32'h0000_0003);
        repeat (2) @(negedge Clk);
        #2 do_reset();
        repeat (DIV_N + 3) @(negedge Clk);

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            issue(op, a, b);
            repeat ($urandom_range(0, 12)) @(negedge Clk);
        end

        drain = 0;
        while (q.size() != 0 && drain < 30) begin
            @(negedge Clk);
            drain++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected results still pending, required 0", q.size());
        end
        @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
